// File: rtl/mem_sweep_initiator_2ports.sv
`default_nettype none
// ============================================================================
//  Module   : mem_sweep_initiator_2ports
//  Purpose  : Dual-port val/rdy mem-msg initiator. On go it writes a seeded
//             pattern across a word range, reads it back and checks every
//             response. Port 0 owns even word indices, port 1 owns odd ones.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_sweep_initiator_2ports #(
    parameter int p_opaque_nbits    = 8,
    parameter int p_addr_nbits      = 32,
    parameter int p_data_nbits      = 32,
    parameter int p_max_outstanding = 4
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   go_i,
    input  logic [p_addr_nbits-1:0]                                base_addr_i,
    input  logic [15:0]                                            num_words_i,
    input  logic [p_data_nbits-1:0]                                seed_i,
    output logic                                                   memreq0_val_o,
    input  logic                                                   memreq0_rdy_i,
    output logic [3+p_opaque_nbits+p_addr_nbits+2+p_data_nbits-1:0] memreq0_msg_o,
    input  logic                                                   memresp0_val_i,
    output logic                                                   memresp0_rdy_o,
    input  logic [3+p_opaque_nbits+2+2+p_data_nbits-1:0]           memresp0_msg_i,
    output logic                                                   memreq1_val_o,
    input  logic                                                   memreq1_rdy_i,
    output logic [3+p_opaque_nbits+p_addr_nbits+2+p_data_nbits-1:0] memreq1_msg_o,
    input  logic                                                   memresp1_val_i,
    output logic                                                   memresp1_rdy_o,
    input  logic [3+p_opaque_nbits+2+2+p_data_nbits-1:0]           memresp1_msg_i,
    output logic                                                   done_o,
    output logic                                                   pass_o,
    output logic [15:0]                                            err_count_o,
    output logic [p_addr_nbits-1:0]                                first_err_addr_o
);
    localparam int c_O      = p_opaque_nbits;
    localparam int c_A      = p_addr_nbits;
    localparam int c_D      = p_data_nbits;
    localparam int c_REQ_W  = 3 + c_O + c_A + 2 + c_D;
    localparam int c_RESP_W = 3 + c_O + 2 + 2 + c_D;
    localparam int c_OUT_W  = $clog2(p_max_outstanding) + 1;
    localparam logic [c_A-1:0]     c_BYTES   = c_A'(c_D / 8);
    localparam logic [c_OUT_W-1:0] c_MAX_OUT = c_OUT_W'(p_max_outstanding);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_WDRAIN = 3'd2,
        S_READ   = 3'd3,
        S_RDRAIN = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [c_A-1:0]     base_q;
    logic [15:0]        num_q;
    logic [c_D-1:0]     seed_q;
    logic [15:0]        err_q, err_d;
    logic [c_A-1:0]     ferr_q, ferr_d;
    logic               done_q, done_d, pass_q, pass_d;
    logic [17:0]        w_err_sum;

    logic               w_go_accept, w_to_read, w_sweeping, w_wr_phase, w_issuing;
    logic [1:0]         w_req_val, w_req_rdy, w_req_fire, w_rsp_val, w_rsp_fire;
    logic [1:0]         w_issue_done, w_outs_zero, w_err;
    logic [c_A-1:0]     w_err_addr [2];
    logic [c_REQ_W-1:0] w_req_msg  [2];
    logic [c_RESP_W-1:0] w_rsp_msg [2];

    assign w_req_rdy    = {memreq1_rdy_i, memreq0_rdy_i};
    assign w_rsp_val    = {memresp1_val_i, memresp0_val_i};
    assign w_rsp_msg[0] = memresp0_msg_i;
    assign w_rsp_msg[1] = memresp1_msg_i;

    assign memreq0_val_o  = w_req_val[0];
    assign memreq1_val_o  = w_req_val[1];
    assign memreq0_msg_o  = w_req_msg[0];
    assign memreq1_msg_o  = w_req_msg[1];
    // Responses are always accepted; outside a sweep they are counted as errors.
    assign memresp0_rdy_o = 1'b1;
    assign memresp1_rdy_o = 1'b1;

    assign w_go_accept = go_i && (state_q == S_IDLE || state_q == S_DONE);
    assign w_sweeping  = !(state_q == S_IDLE || state_q == S_DONE);
    assign w_wr_phase  = (state_q == S_WRITE) || (state_q == S_WDRAIN);
    assign w_issuing   = (state_q == S_WRITE) || (state_q == S_READ);
    assign w_to_read   = w_wr_phase && (state_d == S_READ);

    // Sweep sequencing; drain states are skipped when nothing is outstanding.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (w_go_accept) state_d = S_WRITE;
            S_WRITE:  if (&w_issue_done) state_d = (&w_outs_zero) ? S_READ : S_WDRAIN;
            S_WDRAIN: if (&w_outs_zero)  state_d = S_READ;
            S_READ:   if (&w_issue_done) state_d = (&w_outs_zero) ? S_DONE : S_RDRAIN;
            S_RDRAIN: if (&w_outs_zero)  state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [15:0]        issued_q, rsp_idx_q, w_nwords;
        logic [c_OUT_W-1:0] outs_q;
        logic [c_O-1:0]     seq_q, rsp_opq_q, w_rsp_opq;
        logic [c_A-1:0]     w_req_addr, w_exp_addr;
        logic [c_D-1:0]     w_req_data, w_rsp_data;
        logic [2:0]         w_rsp_type;
        logic               w_rsp_spare, w_bad;

        // Port 0 gets ceil(n/2) words, port 1 gets floor(n/2).
        assign w_nwords        = 16'((17'(num_q) + 17'(1 - p)) >> 1);
        assign w_issue_done[p] = (issued_q >= w_nwords);
        assign w_outs_zero[p]  = (outs_q == '0);
        assign w_req_val[p]    = w_issuing && !w_issue_done[p] && (outs_q < c_MAX_OUT);
        assign w_req_fire[p]   = w_req_val[p] && w_req_rdy[p];
        assign w_rsp_fire[p]   = w_rsp_val[p];

        // Word index k = 2*j + p, so the port bit is the index LSB.
        assign w_req_addr    = base_q + c_A'({issued_q, 1'(p)}) * c_BYTES;
        assign w_req_data    = (state_q == S_WRITE) ? (seed_q ^ c_D'(w_req_addr)) : '0;
        assign w_req_msg[p]  = {(state_q == S_WRITE) ? 3'd1 : 3'd0, seq_q, w_req_addr,
                                2'b00, w_req_data};

        assign w_rsp_type  = w_rsp_msg[p][c_RESP_W-1 -: 3];
        assign w_rsp_opq   = w_rsp_msg[p][c_RESP_W-4 -: c_O];
        assign w_rsp_data  = w_rsp_msg[p][c_D-1:0];
        // test/len carry nothing for this initiator; folded so every bit has a reader.
        assign w_rsp_spare = ^w_rsp_msg[p][c_D+3 -: 4];
        // Responses come back in order, so the response index names the word.
        assign w_exp_addr  = base_q + c_A'({rsp_idx_q, 1'(p)}) * c_BYTES;
        assign w_bad       = !w_sweeping
                           || (w_rsp_type != (w_wr_phase ? 3'd1 : 3'd0))
                           || (w_rsp_opq != rsp_opq_q)
                           || (!w_wr_phase && (w_rsp_data != (seed_q ^ c_D'(w_exp_addr))));
        assign w_err[p]      = w_rsp_fire[p] && (w_bad || (w_rsp_spare && 1'b0));
        assign w_err_addr[p] = w_sweeping ? w_exp_addr : '0;

        // Per-port issue/response indices, outstanding count and opaque sequence.
        always_ff @(posedge clk) begin
            if (reset || w_go_accept) begin
                issued_q  <= '0;
                rsp_idx_q <= '0;
                outs_q    <= '0;
                seq_q     <= '0;
                rsp_opq_q <= '0;
            end else begin
                if (w_to_read) begin
                    issued_q  <= '0;
                    rsp_idx_q <= '0;
                end else begin
                    issued_q  <= issued_q + 16'(w_req_fire[p]);
                    rsp_idx_q <= rsp_idx_q + 16'(w_rsp_fire[p] && w_sweeping);
                end
                seq_q     <= seq_q + c_O'(w_req_fire[p]);
                rsp_opq_q <= rsp_opq_q + c_O'(w_rsp_fire[p] && w_sweeping);
                if (w_req_fire[p] && !w_rsp_fire[p]) begin
                    outs_q <= outs_q + c_OUT_W'(1);
                end else if (!w_req_fire[p] && w_rsp_fire[p] && outs_q != '0) begin
                    outs_q <= outs_q - c_OUT_W'(1);
                end
            end
        end
    end

    // Error accumulation and completion status; port 0 wins a same-cycle tie.
    always_comb begin
        w_err_sum = 18'(err_q) + 18'(w_err[0]) + 18'(w_err[1]);
        err_d     = err_q;
        ferr_d    = ferr_q;
        if (w_go_accept) begin
            err_d  = '0;
            ferr_d = '0;
        end else begin
            err_d = (w_err_sum > 18'h0FFFF) ? 16'hFFFF : w_err_sum[15:0];
            if (err_q == 16'd0 && (|w_err)) begin
                ferr_d = w_err[0] ? w_err_addr[0] : w_err_addr[1];
            end
        end
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == 16'd0);
    end

    // State, latched sweep inputs and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            num_q   <= '0;
            seed_q  <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_go_accept) begin
                base_q <= base_addr_i;
                num_q  <= num_words_i;
                seed_q <= seed_i;
            end
            err_q  <= err_d;
            ferr_q <= ferr_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_sweep_initiator_2ports.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_sweep_initiator_2ports
//  Purpose  : Self-checking bench: in-order dual-port memory responder with
//             random delays, expected request streams built from the word
//             rules, and end-of-sweep status checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sweep_initiator_2ports;
    localparam int c_REQW  = 77;
    localparam int c_RESPW = 47;

    typedef struct { logic [2:0] typ; logic [31:0] addr; logic [31:0] data; } exp_t;
    typedef struct { int t; logic [c_RESPW-1:0] msg; } rsp_t;
    typedef struct {
        logic [31:0] base; int num; logic [31:0] seed; int maxd;
        bit cen; logic [31:0] caddr; int exp_err; logic [31:0] exp_first;
        bit exp_pass; bit mid_go;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, go;
    logic [31:0] base_addr, seed;
    logic [15:0] num_words;
    logic req_val0, req_val1, req_rdy0, req_rdy1;
    logic rsp_val0, rsp_val1, rsp_rdy0, rsp_rdy1;
    logic [c_REQW-1:0]  req_msg0, req_msg1;
    logic [c_RESPW-1:0] rsp_msg0, rsp_msg1;
    logic done, pass;
    logic [15:0] err_count;
    logic [31:0] first_err;

    mem_sweep_initiator_2ports dut (
        .clk(clk), .reset(reset), .go_i(go), .base_addr_i(base_addr),
        .num_words_i(num_words), .seed_i(seed),
        .memreq0_val_o(req_val0), .memreq0_rdy_i(req_rdy0), .memreq0_msg_o(req_msg0),
        .memresp0_val_i(rsp_val0), .memresp0_rdy_o(rsp_rdy0), .memresp0_msg_i(rsp_msg0),
        .memreq1_val_o(req_val1), .memreq1_rdy_i(req_rdy1), .memreq1_msg_o(req_msg1),
        .memresp1_val_i(rsp_val1), .memresp1_rdy_o(rsp_rdy1), .memresp1_msg_i(rsp_msg1),
        .done_o(done), .pass_o(pass), .err_count_o(err_count), .first_err_addr_o(first_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t exp_q [2][$];
    rsp_t rsp_q [2][$];
    logic [31:0] mem [logic [31:0]];
    int   req_n [2];
    int   exp_cnt [2];
    int   outs [2];
    int   max_outs [2];
    bit   stalled [2];
    logic [c_REQW-1:0] stall_msg [2];
    int   wr_pending;
    bit   saw_read;
    int   max_delay;
    bit   cen;
    logic [31:0] caddr;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_port(input int p, input logic rdy, input logic rv, input logic [c_RESPW-1:0] rm);
        if (p == 0) begin req_rdy0 = rdy; rsp_val0 = rv; rsp_msg0 = rm; end
        else        begin req_rdy1 = rdy; rsp_val1 = rv; rsp_msg1 = rm; end
    endtask

    // One responder step per port, decided at the falling edge for the next rising edge.
    task automatic serve_port(input int p);
        logic v, r, rv, rr;
        logic [c_REQW-1:0] m;
        logic [c_RESPW-1:0] rm;
        logic [2:0] t;
        logic [7:0] o;
        logic [31:0] a, d, rd;
        exp_t e;
        rsp_t rs;
        if (reset) begin
            rsp_q[p].delete();
            outs[p] = 0;
            stalled[p] = 0;
            drive_port(p, 1'b0, 1'b0, '0);
            return;
        end
        v  = (p == 0) ? req_val0 : req_val1;
        m  = (p == 0) ? req_msg0 : req_msg1;
        rr = (p == 0) ? rsp_rdy0 : rsp_rdy1;
        if (stalled[p]) begin
            check("hold_val", {127'd0, v}, 128'd1);
            check("hold_msg", m, stall_msg[p]);
        end
        rv = (rsp_q[p].size() > 0) && (rsp_q[p][0].t <= cyc);
        rm = rv ? rsp_q[p][0].msg : '0;
        r  = (max_delay == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        drive_port(p, r, rv, rm);
        if (v && r) begin
            t = m[76:74]; o = m[73:66]; a = m[65:34]; d = m[31:0];
            if (exp_q[p].size() == 0) begin
                check("unexpected_req", {51'd0, m}, 128'd0);
            end else begin
                e = exp_q[p].pop_front();
                check("req_fields",
                      {51'd0, t, o, a, m[33:32], (t == 3'd1) ? d : 32'h0},
                      {51'd0, e.typ, 8'(req_n[p]), e.addr, 2'b00, (e.typ == 3'd1) ? e.data : 32'h0});
            end
            if (t == 3'd1) begin
                mem[a] = d;
                rd = 32'h0;
                wr_pending++;
            end else begin
                check("rd_after_wr", 128'(wr_pending), 128'd0);
                saw_read = 1;
                rd = mem.exists(a) ? mem[a] : 32'h0;
                if (cen && a == caddr) rd = rd ^ 32'h1;
            end
            rs.t   = cyc + 1 + ((max_delay == 0) ? 0 : int'($urandom_range(0, max_delay)));
            rs.msg = {t, o, 2'b00, 2'b00, rd};
            rsp_q[p].push_back(rs);
            req_n[p]++;
            outs[p]++;
            if (outs[p] > max_outs[p]) max_outs[p] = outs[p];
        end
        if (rv && rr) begin
            rs = rsp_q[p].pop_front();
            outs[p]--;
            if (rs.msg[46:44] == 3'd1) wr_pending--;
        end
        stalled[p]   = v && !r;
        stall_msg[p] = m;
    endtask

    initial begin : responder
        req_rdy0 = 0; req_rdy1 = 0; rsp_val0 = 0; rsp_val1 = 0; rsp_msg0 = '0; rsp_msg1 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int p = 0; p < 2; p++) serve_port(p);
        end
    end

    // Build the expected streams from the word rules and pulse go.
    task automatic start_sweep(input logic [31:0] b, input int num, input logic [31:0] s,
                               input int md, input bit ce, input logic [31:0] ca);
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            exp_q[p].delete();
            for (int typ = 1; typ >= 0; typ--) begin
                for (int k = p; k < num; k += 2) begin
                    e.typ  = 3'(typ);
                    e.addr = b + 32'(k * 4);
                    e.data = s ^ e.addr;
                    exp_q[p].push_back(e);
                end
            end
            exp_cnt[p] = exp_q[p].size();
            req_n[p] = 0; outs[p] = 0; max_outs[p] = 0;
        end
        wr_pending = 0; saw_read = 0;
        max_delay = md; cen = ce; caddr = ca;
        base_addr = b; num_words = 16'(num); seed = s;
        go = 1;
        tick();
        go = 0;
        check("go_clear", {78'd0, done, pass, err_count, first_err}, 128'd0);
    endtask

    task automatic finish_sweep(input int num, input bit mid_go, input int exp_err,
                                input logic [31:0] exp_first, input bit exp_pass);
        int n = 0;
        while (done !== 1'b1 && n < 20000) begin
            go = mid_go && (n == 3);
            tick();
            n++;
        end
        go = 0;
        check("done_seen", {127'd0, done}, 128'd1);
        if (num == 0) check("zero_latency", {127'd0, (n <= 4)}, 128'd1);
        check("req_count0", 128'(req_n[0]), 128'(exp_cnt[0]));
        check("req_count1", 128'(req_n[1]), 128'(exp_cnt[1]));
        check("err_count", {112'd0, err_count}, 128'(exp_err));
        check("first_err_addr", {96'd0, first_err}, {96'd0, exp_first});
        check("pass", {127'd0, pass}, {127'd0, exp_pass});
        check("max_outstanding", {127'd0, (max_outs[0] <= 4 && max_outs[1] <= 4)}, 128'd1);
    endtask

    vec_t vecs [8];

    initial begin : main
        int k, num;
        logic [31:0] b;
        bit ce;
        reset = 1; go = 0; base_addr = 0; num_words = 0; seed = 0;
        max_delay = 0; cen = 0; caddr = 0; wr_pending = 0; saw_read = 0;
        repeat (3) tick();
        reset = 0;
        tick();
        check("reset_state", {76'd0, req_val0, req_val1, done, pass, err_count, first_err}, 128'd0);

        vecs[0] = '{32'h0000_1000,   8, 32'hA5A5_A5A5,  0, 0, 32'h0,      0, 32'h0,      1, 0};
        vecs[1] = '{32'h0000_1000,   8, 32'hA5A5_A5A5, 10, 0, 32'h0,      0, 32'h0,      1, 1};
        vecs[2] = '{32'h0000_1000,   1, 32'hA5A5_A5A5,  3, 0, 32'h0,      0, 32'h0,      1, 0};
        vecs[3] = '{32'h0000_1000,   8, 32'hA5A5_A5A5,  0, 1, 32'h100C,   1, 32'h100C,   0, 0};
        vecs[4] = '{32'hFFFF_FFF8,   4, 32'h0F0F_0F0F,  3, 0, 32'h0,      0, 32'h0,      1, 0};
        vecs[5] = '{32'h0000_2000, 600, 32'h1234_5678,  0, 0, 32'h0,      0, 32'h0,      1, 0};
        vecs[6] = '{32'h0000_0000,   9, 32'hDEAD_BEEF,  5, 1, 32'h20,     1, 32'h20,     0, 0};
        vecs[7] = '{32'h0000_0040,   0, 32'h5555_AAAA,  0, 0, 32'h0,      0, 32'h0,      1, 0};

        for (int i = 0; i < 8; i++) begin
            start_sweep(vecs[i].base, vecs[i].num, vecs[i].seed, vecs[i].maxd,
                        vecs[i].cen, vecs[i].caddr);
            finish_sweep(vecs[i].num, vecs[i].mid_go, vecs[i].exp_err,
                         vecs[i].exp_first, vecs[i].exp_pass);
        end

        // A response arriving while DONE is an error logged at address 0.
        rsp_q[0].push_back('{0, {3'd0, 8'h00, 4'h0, 32'h0}});
        repeat (3) tick();
        check("stray_rsp_err", {112'd0, err_count}, 128'd1);
        check("stray_rsp_addr_pass", {95'd0, done, pass, first_err}, {95'd0, 1'b1, 1'b0, 32'h0});

        // Reset during the read phase, then a clean sweep across the address wrap.
        start_sweep(32'h0000_3000, 40, 32'hC3C3_3C3C, 4, 0, 32'h0);
        k = 0;
        while (!saw_read && k < 20000) begin tick(); k++; end
        check("reached_read", {127'd0, saw_read}, 128'd1);
        reset = 1;
        tick();
        check("mid_reset_outputs", {76'd0, req_val0, req_val1, done, pass, err_count, first_err}, 128'd0);
        reset = 0;
        exp_q[0].delete(); exp_q[1].delete(); wr_pending = 0;
        tick();
        start_sweep(32'hFFFF_FFF8, 4, 32'h0F0F_0F0F, 3, 0, 32'h0);
        finish_sweep(4, 0, 0, 32'h0, 1);

        // Randomized sweeps with an optional corrupted word.
        for (int i = 0; i < 6; i++) begin
            b   = $urandom & 32'hFFFF_FFFC;
            num = int'($urandom_range(0, 20));
            k   = int'($urandom_range(0, num));
            ce  = bit'($urandom_range(0, 1));
            start_sweep(b, num, $urandom, int'($urandom_range(0, 6)), ce, b + 32'(k * 4));
            if (ce && k < num) finish_sweep(num, 0, 1, b + 32'(k * 4), 0);
            else               finish_sweep(num, 0, 0, 32'h0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
